ccip_rd_arbiter: RTL and testbench
==================================

CCIP_RD_ARBITER -- requirements
Module: ccip_rd_arbiter

Interface
REQ-001: Parameter NUM_REQ, default 4, number of read requesters (power of two, 2..8).
REQ-002: Parameter MAX_OUTST, default 64, maximum outstanding reads per requester.
REQ-003: Parameter ADDR_W, default 42, cache-line address width.
REQ-004: pClk  in  1  sole clock; all state changes on rising edge.
REQ-005: pck_cp2af_softReset  in  1  synchronous, active-high reset.
REQ-006: req_valid  in  NUM_REQ  per-requester read request valid.
REQ-007: req_addr  in  NUM_REQ*ADDR_W  per-requester line address; requester i occupies slice i.
REQ-008: req_tag  in  NUM_REQ*(16-log2(NUM_REQ))  per-requester tag, returned with the response.
REQ-009: req_ready  out  NUM_REQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i].
REQ-010: c0_tx_valid  out  1  CCI-P c0 read request valid.
REQ-011: c0_tx_addr  out  ADDR_W  read address.
REQ-012: c0_tx_mdata  out  16  {tag, requester id}; id in the low log2(NUM_REQ) bits.
REQ-013: c0_tx_almfull  in  1  CCI-P c0 almost-full.
REQ-014: c0_rx_rdvalid  in  1  read response valid.
REQ-015: c0_rx_mdata  in  16  response mdata.
REQ-016: c0_rx_data  in  512  response data.
REQ-017: rsp_valid  out  NUM_REQ  one-hot response strobe.
REQ-018: rsp_tag  out  16-log2(NUM_REQ)  returned tag.
REQ-019: rsp_data  out  512  returned data.
REQ-020: drain_req  in  1  level; stop new grants and wait for quiescence.
REQ-021: drain_done  out  1  high in DRAIN when all outstanding counters are 0.
REQ-022: err_underflow  out  1  sticky; response arrived for a requester with 0 outstanding.

Function
REQ-023: FSM states RUN, DRAIN; reset to RUN.
REQ-024: RUN->DRAIN when drain_req=1; DRAIN->RUN when drain_req=0 (takes effect next cycle).
REQ-025: Requester i eligible = req_valid[i] && outst[i] < MAX_OUTST.
REQ-026: A grant is issued only in RUN with c0_tx_almfull=0 in the same cycle.
REQ-027: Grant is round-robin: search starts at rr_ptr; pick first eligible index modulo NUM_REQ.
REQ-028: On grant to i, rr_ptr <= (i+1) mod NUM_REQ; no grant leaves rr_ptr unchanged.
REQ-029: req_ready is combinational from req_valid, outst, almfull and state; at most one bit set.
REQ-030: Accepted request appears on c0_tx_valid/addr/mdata exactly 1 cycle later (registered); c0_tx_valid=0 otherwise.
REQ-031: Issue rate is at most one request per cycle; back-to-back grants are permitted.
REQ-032: outst[i] width clog2(MAX_OUTST+1); +1 on grant to i, -1 on response to i; simultaneous grant and response to the same i leaves it unchanged.
REQ-033: Response: c0_rx_rdvalid routes to id=c0_rx_mdata low bits; rsp_valid[id], rsp_tag, rsp_data are registered 1 cycle later.
REQ-034: rsp_valid=0 when no response; rsp_tag/rsp_data hold last value.
REQ-035: Response with outst[id]=0 sets err_underflow, leaves counter at 0, still strobes rsp_valid.
REQ-036: drain_done = (state==DRAIN) && all outst==0, combinational from registered state.
REQ-037: Responses are processed in both states; only grants are blocked in DRAIN.

Reset
REQ-038: While softReset is high at a clock edge: state=RUN, rr_ptr=0, all outst=0, c0_tx_valid=0, rsp_valid=0, err_underflow=0, c0_tx_addr/mdata/rsp_tag/rsp_data=0.
REQ-039: req_ready=0 during any cycle softReset is high.
REQ-040: Reset mid-operation discards outstanding counts; later responses for pre-reset requests set err_underflow.

Verification
REQ-041: All 4 valid continuously, almfull=0 -> grants 0,1,2,3,0..., one per cycle; c0_tx_mdata[1:0] follows the same sequence 1 cycle late.
REQ-042: Requester 2 issues 64 reads with no responses (MAX_OUTST=64) -> 65th blocked with req_ready[2]=0; others still granted; one response to id 2 -> grant resumes next cycle.
REQ-043: almfull=1 for 5 cycles with all valid -> req_ready=0 and c0_tx_valid=0 in the following cycles; first grant after almfull drops goes to rr_ptr.
REQ-044: Grant and response for requester 1 in the same cycle with outst[1]=3 -> outst[1] stays 3.
REQ-045: drain_req=1 with 5 outstanding -> no grants; drain_done rises the cycle after the 5th response; drain_req=0 -> grants resume.
REQ-046: Response with mdata id=3 after reset -> rsp_valid[3]=1 next cycle, err_underflow=1 and sticky until reset.

Source files
------------

// File: rtl/ccip_rd_arbiter.sv
// Round-robin arbiter for NUM_REQ read requesters onto the CCI-P c0 channel,
// with per-requester outstanding-read tracking, response routing and drain.
module ccip_rd_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_OUTST = 64,
    parameter int unsigned ADDR_W    = 42
) (
    input  logic                                      pClk,
    input  logic                                      pck_cp2af_softReset,
    input  logic [NUM_REQ-1:0]                        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]                 req_addr,
    input  logic [NUM_REQ*(16-$clog2(NUM_REQ))-1:0]   req_tag,
    output logic [NUM_REQ-1:0]                        req_ready,
    output logic                                      c0_tx_valid,
    output logic [ADDR_W-1:0]                         c0_tx_addr,
    output logic [15:0]                               c0_tx_mdata,
    input  logic                                      c0_tx_almfull,
    input  logic                                      c0_rx_rdvalid,
    input  logic [15:0]                               c0_rx_mdata,
    input  logic [511:0]                              c0_rx_data,
    output logic [NUM_REQ-1:0]                        rsp_valid,
    output logic [15-$clog2(NUM_REQ):0]               rsp_tag,
    output logic [511:0]                              rsp_data,
    input  logic                                      drain_req,
    output logic                                      drain_done,
    output logic                                      err_underflow
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned TAG_W = 16 - ID_W;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                        state;
    logic [ID_W-1:0]               rr_ptr;
    logic [NUM_REQ-1:0][CNT_W-1:0] outst;
    logic [NUM_REQ-1:0]            eligible;
    logic [NUM_REQ-1:0]            inc;
    logic [NUM_REQ-1:0]            hit;
    logic [ID_W-1:0]               cand;
    logic [ID_W-1:0]               gnt_id;
    logic                          grant;
    logic [ID_W-1:0]               rx_id;

    assign rx_id = c0_rx_mdata[ID_W-1:0];

    always_comb begin
        eligible = '0;
        inc      = '0;
        hit      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (outst[i] < CNT_W'(MAX_OUTST));
            inc[i]      = grant && (gnt_id == ID_W'(i));
            hit[i]      = c0_rx_rdvalid && (rx_id == ID_W'(i));
        end
    end

    // Walk from the farthest offset back to rr_ptr so the nearest eligible wins.
    always_comb begin
        grant  = 1'b0;
        gnt_id = '0;
        cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = rr_ptr + ID_W'(k);
            if (eligible[cand]) begin
                grant  = 1'b1;
                gnt_id = cand;
            end
        end
        if (pck_cp2af_softReset || (state != RUN) || c0_tx_almfull) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign drain_done = (state == DRAIN) && (outst == '0);

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            state         <= RUN;
            rr_ptr        <= '0;
            outst         <= '0;
            c0_tx_valid   <= 1'b0;
            c0_tx_addr    <= '0;
            c0_tx_mdata   <= '0;
            rsp_valid     <= '0;
            rsp_tag       <= '0;
            rsp_data      <= '0;
            err_underflow <= 1'b0;
        end else begin
            state       <= drain_req ? DRAIN : RUN;
            c0_tx_valid <= grant;
            if (grant) begin
                rr_ptr      <= gnt_id + ID_W'(1);
                c0_tx_addr  <= req_addr[gnt_id*ADDR_W +: ADDR_W];
                c0_tx_mdata <= {req_tag[gnt_id*TAG_W +: TAG_W], gnt_id};
            end
            rsp_valid <= '0;
            if (c0_rx_rdvalid) begin
                rsp_valid[rx_id] <= 1'b1;
                rsp_tag          <= c0_rx_mdata[15:ID_W];
                rsp_data         <= c0_rx_data;
                if (outst[rx_id] == '0) begin
                    err_underflow <= 1'b1;
                end
            end
            // Grant and response to the same requester cancel out.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inc[i] && !hit[i]) begin
                    outst[i] <= outst[i] + CNT_W'(1);
                end else if (hit[i] && !inc[i] && (outst[i] != '0)) begin
                    outst[i] <= outst[i] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// Randomized and directed bench for ccip_rd_arbiter; a reference model predicts
// grants and responses, a monitor checks the registered outputs.
module tb_ccip_rd_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 64;
    localparam int AW   = 42;
    localparam int IDW  = 2;
    localparam int TW   = 14;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N*AW-1:0]     req_addr;
    logic [N*TW-1:0]     req_tag;
    logic [N-1:0]        req_ready;
    logic                c0_tx_valid;
    logic [AW-1:0]       c0_tx_addr;
    logic [15:0]         c0_tx_mdata;
    logic                c0_tx_almfull;
    logic                c0_rx_rdvalid;
    logic [15:0]         c0_rx_mdata;
    logic [511:0]        c0_rx_data;
    logic [N-1:0]        rsp_valid;
    logic [TW-1:0]       rsp_tag;
    logic [511:0]        rsp_data;
    logic                drain_req;
    logic                drain_done;
    logic                err_underflow;

    always #5 clk = ~clk;

    ccip_rd_arbiter #(.NUM_REQ(N), .MAX_OUTST(MAXO), .ADDR_W(AW)) dut (
        .pClk(clk), .pck_cp2af_softReset(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
        .c0_tx_valid(c0_tx_valid), .c0_tx_addr(c0_tx_addr), .c0_tx_mdata(c0_tx_mdata),
        .c0_tx_almfull(c0_tx_almfull), .c0_rx_rdvalid(c0_rx_rdvalid), .c0_rx_mdata(c0_rx_mdata),
        .c0_rx_data(c0_rx_data), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .drain_req(drain_req), .drain_done(drain_done), .err_underflow(err_underflow)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   mdata;
    } tx_t;

    typedef struct packed {
        logic [N-1:0]  v;
        logic [TW-1:0] tag;
        logic [511:0]  data;
    } rsp_t;

    tx_t  txq[$];
    rsp_t rq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit   m_drain;
    int   m_rr;
    int   m_outst[N];
    bit   m_err;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input bit af, input bit r);
        if (r || af || m_drain) return -1;
        for (int k = 0; k < N; k++) begin
            int i = (m_rr + k) % N;
            if (v[i] && m_outst[i] < MAXO) return i;
        end
        return -1;
    endfunction

    function automatic bit all_idle();
        for (int i = 0; i < N; i++) if (m_outst[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_cycle(input bit r, input logic [N-1:0] v, input bit af,
                            input bit rdv, input int rid, input bit drn);
        logic [63:0]  t;
        logic [511:0] d;
        logic [511:0] exp_ready;
        int           g;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            t = {$urandom, $urandom};
            req_addr[i*AW +: AW] = t[AW-1:0];
            req_tag[i*TW +: TW]  = TW'($urandom);
        end
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
        c0_tx_almfull = af;
        c0_rx_rdvalid = rdv;
        c0_rx_mdata   = {TW'($urandom), IDW'(rid)};
        c0_rx_data    = d;
        drain_req     = drn;
        #1;
        g = model_grant(v, af, r);
        exp_ready = (g >= 0) ? (512'(1) << g) : '0;
        check("req_ready", req_ready, exp_ready);
        if (!r) begin
            check("drain_done", drain_done, m_drain && all_idle());
            check("err_underflow", err_underflow, m_err);
        end
        if (g >= 0) txq.push_back('{addr: req_addr[g*AW +: AW], mdata: {req_tag[g*TW +: TW], IDW'(g)}});
        if (rdv && !r) rq.push_back('{v: N'(1 << rid), tag: c0_rx_mdata[15:IDW], data: c0_rx_data});
        @(posedge clk);
        if (r) begin
            m_drain = 1'b0;
            m_rr    = 0;
            m_err   = 1'b0;
            for (int i = 0; i < N; i++) m_outst[i] = 0;
        end else begin
            if (rdv && m_outst[rid] == 0) m_err = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (g == i && !(rdv && rid == i)) m_outst[i]++;
                else if (rdv && rid == i && g != i && m_outst[i] > 0) m_outst[i]--;
            end
            if (g >= 0) m_rr = (g + 1) % N;
            m_drain = drn;
        end
    endtask

    // Monitor: every registered output must match what the model queued last cycle.
    initial begin
        tx_t  et;
        rsp_t er;
        forever begin
            @(posedge clk);
            #2;
            check("c0_tx_valid", c0_tx_valid, txq.size() > 0);
            if (txq.size() > 0) begin
                et = txq.pop_front();
                if (c0_tx_valid === 1'b1) begin
                    check("c0_tx_addr", c0_tx_addr, et.addr);
                    check("c0_tx_mdata", c0_tx_mdata, et.mdata);
                end
            end
            check("rsp_valid", rsp_valid, (rq.size() > 0) ? rq[0].v : '0);
            if (rq.size() > 0) begin
                er = rq.pop_front();
                if (rsp_valid !== '0) begin
                    check("rsp_tag", rsp_tag, er.tag);
                    check("rsp_data", rsp_data, er.data);
                end
            end
        end
    end

    initial begin
        int         rid;
        int         live[$];
        bit         drn;
        rst = 1'b1; req_valid = '0; req_addr = '0; req_tag = '0; c0_tx_almfull = 1'b0;
        c0_rx_rdvalid = 1'b0; c0_rx_mdata = '0; c0_rx_data = '0; drain_req = 1'b0;
        m_drain = 1'b0; m_rr = 0; m_err = 1'b0;
        for (int i = 0; i < N; i++) m_outst[i] = 0;

        repeat (2) do_cycle(1, '0, 0, 0, 0, 0);
        #2;
        check("reset_tx_addr", c0_tx_addr, '0);
        check("reset_tx_mdata", c0_tx_mdata, '0);
        check("reset_rsp_tag", rsp_tag, '0);
        check("reset_rsp_data", rsp_data, '0);
        check("reset_err", err_underflow, 1'b0);

        // Round-robin with all requesters valid, then retire everything
        repeat (8) do_cycle(0, 4'hF, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) repeat (2) do_cycle(0, '0, 0, 1, i, 0);

        // Requester 2 saturates at MAX_OUTST, then one response reopens it
        do_cycle(1, '0, 0, 0, 0, 0);
        repeat (MAXO) do_cycle(0, 4'b0100, 0, 0, 0, 0);
        repeat (4) do_cycle(0, 4'hF, 0, 0, 0, 0);
        do_cycle(0, 4'b0100, 0, 1, 2, 0);
        repeat (2) do_cycle(0, 4'b0100, 0, 0, 0, 0);

        // Almost-full blocks grants; resumption starts at rr_ptr
        repeat (5) do_cycle(0, 4'hF, 1, 0, 0, 0);
        repeat (3) do_cycle(0, 4'hF, 0, 0, 0, 0);

        // Simultaneous grant and response to requester 1 with 3 outstanding
        do_cycle(1, '0, 0, 0, 0, 0);
        repeat (3) do_cycle(0, 4'b0010, 0, 0, 0, 0);
        do_cycle(0, 4'b0010, 0, 1, 1, 0);
        repeat (4) do_cycle(0, '0, 0, 1, 1, 0);

        // Drain with 5 outstanding
        do_cycle(1, '0, 0, 0, 0, 0);
        repeat (5) do_cycle(0, 4'hF, 0, 0, 0, 0);
        repeat (2) do_cycle(0, 4'hF, 0, 0, 0, 1);
        foreach (live[i]) live.delete(i);
        for (int i = 0; i < 5; i++) do_cycle(0, 4'hF, 0, 1, i % N, 1);
        repeat (2) do_cycle(0, 4'hF, 0, 0, 0, 1);
        repeat (3) do_cycle(0, 4'hF, 0, 0, 0, 0);

        // Response with nothing outstanding after reset
        do_cycle(1, '0, 0, 0, 0, 0);
        do_cycle(0, '0, 0, 1, 3, 0);
        repeat (3) do_cycle(0, '0, 0, 0, 0, 0);

        // Random traffic with occasional drain, almost-full and mid-run reset
        do_cycle(1, '0, 0, 0, 0, 0);
        drn = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            live.delete();
            for (int i = 0; i < N; i++) if (m_outst[i] > 0) live.push_back(i);
            if (live.size() > 0 && ($urandom % 10) != 0) rid = live[$urandom % live.size()];
            else rid = $urandom % N;
            if (($urandom % 50) == 0) drn = ~drn;
            do_cycle(($urandom % 500) == 0, N'($urandom), ($urandom % 5) == 0,
                     ($urandom % 2) == 0, rid, drn);
        end
        repeat (3) do_cycle(0, '0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
